// File: rtl/ksa_pipe_addsub.sv
// Pipelined Kogge-Stone adder/subtractor: operand prep register, one register per
// prefix level, and a registered sum/overflow/saturation output stage.
module ksa_pipe_addsub #(
    parameter int WIDTH = 16,
    parameter bit SAT   = 1'b0,
    localparam int LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_valid,
    input  logic             i_sub,
    input  logic             i_cin,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_s,
    output logic             o_carry,
    output logic             o_ovf
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] p_in;
    logic [WIDTH-1:0] g_in;
    logic             cin_eff;

    // Carry-in is folded into bit 0's generate so G_i becomes the true carry out of bit i.
    always_comb begin
        b_eff   = i_sub ? ~i_b : i_b;
        cin_eff = i_sub ^ i_cin;
        p_in    = i_a ^ b_eff;
        g_in    = i_a & b_eff;
        g_in[0] = g_in[0] | (p_in[0] & cin_eff);
    end

    // Index 0 is the prep register; index k holds the result of prefix level k.
    logic [WIDTH-1:0] g_q  [0:LEVELS];
    logic [WIDTH-1:0] p_q  [0:LEVELS];
    logic [WIDTH-1:0] po_q [0:LEVELS];
    logic [LEVELS:0]  vld_q;
    logic [LEVELS:0]  cin_q;
    logic [LEVELS:0]  am_q;
    logic [LEVELS:0]  bm_q;

    logic [WIDTH-1:0] g_nxt [1:LEVELS];
    logic [WIDTH-1:0] p_nxt [1:LEVELS];

    always_comb begin
        for (int k = 1; k <= LEVELS; k++) begin
            g_nxt[k] = g_q[k-1];
            p_nxt[k] = p_q[k-1];
            for (int i = (1 << (k - 1)); i < WIDTH; i++) begin
                g_nxt[k][i] = g_q[k-1][i] | (p_q[k-1][i] & g_q[k-1][i - (1 << (k - 1))]);
                p_nxt[k][i] = p_q[k-1][i] & p_q[k-1][i - (1 << (k - 1))];
            end
        end
    end

    // NOTE: datapath registers carry no reset; only the valid bits and outputs need a known state.
    always_ff @(posedge i_clk) begin
        if (i_en) begin
            g_q[0]  <= g_in;
            p_q[0]  <= p_in;
            po_q[0] <= p_in;
            cin_q   <= {cin_q[LEVELS-1:0], cin_eff};
            am_q    <= {am_q[LEVELS-1:0], i_a[WIDTH-1]};
            bm_q    <= {bm_q[LEVELS-1:0], b_eff[WIDTH-1]};
            for (int k = 1; k <= LEVELS; k++) begin
                g_q[k]  <= g_nxt[k];
                p_q[k]  <= p_nxt[k];
                po_q[k] <= po_q[k-1];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vld_q <= '0;
        end else if (i_en) begin
            vld_q <= {vld_q[LEVELS-1:0], i_valid};
        end
    end

    logic [WIDTH-1:0] carry_vec;
    logic [WIDTH-1:0] s_raw;
    logic [WIDTH-1:0] s_out;
    logic             ovf_raw;

    always_comb begin
        carry_vec = {g_q[LEVELS][WIDTH-2:0], cin_q[LEVELS]};
        s_raw     = po_q[LEVELS] ^ carry_vec;
        ovf_raw   = (am_q[LEVELS] == bm_q[LEVELS]) && (s_raw[WIDTH-1] != am_q[LEVELS]);
        s_out     = s_raw;
        if (SAT && ovf_raw) begin
            s_out = am_q[LEVELS] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid <= 1'b0;
            o_s     <= '0;
            o_carry <= 1'b0;
            o_ovf   <= 1'b0;
        end else if (i_en) begin
            o_valid <= vld_q[LEVELS];
            o_s     <= s_out;
            o_carry <= g_q[LEVELS][WIDTH-1];
            o_ovf   <= ovf_raw;
        end
    end

endmodule

// File: tb/tb_ksa_pipe_addsub.sv
// Scoreboard bench for ksa_pipe_addsub: four instances (16-bit wrap, 16-bit saturate,
// 24-bit, 5-bit) share one stimulus stream; a negedge monitor pops and compares.
module tb_ksa_pipe_addsub;

    typedef struct {
        logic [63:0] s;
        bit          c;
        bit          o;
        longint      due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic        sub = 1'b0;
    logic        cin = 1'b0;
    logic [3:0]  v   = 4'b0;
    logic [63:0] a   = '0;
    logic [63:0] b   = '0;

    logic        ov0, ov1, ov2, ov3;
    logic        oc0, oc1, oc2, oc3;
    logic        oo0, oo1, oo2, oo3;
    logic [15:0] s0, s1;
    logic [23:0] s2;
    logic [4:0]  s3;

    int     total = 0;
    int     bad   = 0;
    longint ecnt  = 0;
    bit     last_en = 1'b0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    exp_t q3[$];

    ksa_pipe_addsub #(.WIDTH(16), .SAT(1'b0)) u_w16 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_valid(v[0]), .i_sub(sub), .i_cin(cin),
        .i_a(a[15:0]), .i_b(b[15:0]), .o_valid(ov0), .o_s(s0), .o_carry(oc0), .o_ovf(oo0));
    ksa_pipe_addsub #(.WIDTH(16), .SAT(1'b1)) u_w16s (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_valid(v[1]), .i_sub(sub), .i_cin(cin),
        .i_a(a[15:0]), .i_b(b[15:0]), .o_valid(ov1), .o_s(s1), .o_carry(oc1), .o_ovf(oo1));
    ksa_pipe_addsub #(.WIDTH(24), .SAT(1'b0)) u_w24 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_valid(v[2]), .i_sub(sub), .i_cin(cin),
        .i_a(a[23:0]), .i_b(b[23:0]), .o_valid(ov2), .o_s(s2), .o_carry(oc2), .o_ovf(oo2));
    ksa_pipe_addsub #(.WIDTH(5), .SAT(1'b0)) u_w5 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_valid(v[3]), .i_sub(sub), .i_cin(cin),
        .i_a(a[4:0]), .i_b(b[4:0]), .o_valid(ov3), .o_s(s3), .o_carry(oc3), .o_ovf(oo3));

    always #5 clk = ~clk;

    // Enabled-edge counter: latency is measured in enabled cycles.
    always @(posedge clk) begin
        last_en <= en && !rst;
        if (en && !rst) ecnt <= ecnt + 1;
    end

    function automatic int wid(int i);
        case (i)
            0, 1:    return 16;
            2:       return 24;
            default: return 5;
        endcase
    endfunction

    function automatic bit satm(int i);
        return i == 1;
    endfunction

    function automatic int lat(int i);
        case (i)
            0, 1:    return 6;
            2:       return 7;
            default: return 5;
        endcase
    endfunction

    function automatic string nm(int i);
        case (i)
            0:       return "w16";
            1:       return "w16s";
            2:       return "w24";
            default: return "w5";
        endcase
    endfunction

    function automatic int qsize();
        return q0.size() + q1.size() + q2.size() + q3.size();
    endfunction

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic exp_t model(int i, logic [63:0] a_in, logic [63:0] b_in, bit sub_op, bit ci);
        exp_t   e;
        int     w;
        longint m, ua, ub, ur, sa, sbv, sr, mx, mn, cl;
        w  = wid(i);
        m  = (longint'(1) << w) - 1;
        cl = longint'(ci);
        ua = longint'(a_in) & m;
        ub = longint'(b_in) & m;
        ur = sub_op ? ua - ub - cl : ua + ub + cl;
        e.s = 64'(ur & m);
        e.c = sub_op ? (ua >= ub + cl) : (((ur >> w) & 1) != 0);
        mx = m >> 1;
        mn = -mx - 1;
        sa  = (((ua >> (w - 1)) & 1) != 0) ? ua - (m + 1) : ua;
        sbv = (((ub >> (w - 1)) & 1) != 0) ? ub - (m + 1) : ub;
        sr  = sub_op ? sa - sbv - cl : sa + sbv + cl;
        e.o = (sr > mx) || (sr < mn);
        if (satm(i) && e.o) e.s = 64'(((sr < mn) ? mn : mx) & m);
        e.due = 0;
        return e;
    endfunction

    task automatic check(string n, logic [63:0] got, logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", n, got, want);
        end
    endtask

    task automatic push(int i, exp_t e);
        e.due = ecnt + longint'(lat(i));
        case (i)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            2:       q2.push_back(e);
            default: q3.push_back(e);
        endcase
    endtask

    task automatic mon(int i, logic [63:0] s, logic c, logic o);
        exp_t e;
        int   n;
        case (i)
            0:       n = q0.size();
            1:       n = q1.size();
            2:       n = q2.size();
            default: n = q3.size();
        endcase
        if (n == 0) begin
            total++;
            bad++;
            $display("FAIL %s unexpected o_valid: got 1 want 0", nm(i));
            return;
        end
        case (i)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            2:       e = q2.pop_front();
            default: e = q3.pop_front();
        endcase
        check({nm(i), " s"}, s, e.s);
        check({nm(i), " carry"}, 64'(c), 64'(e.c));
        check({nm(i), " ovf"}, 64'(o), 64'(e.o));
        check({nm(i), " latency"}, 64'(ecnt), 64'(e.due));
    endtask

    always @(negedge clk) begin
        if (last_en) begin
            if (ov0) mon(0, 64'(s0), oc0, oo0);
            if (ov1) mon(1, 64'(s1), oc1, oo1);
            if (ov2) mon(2, 64'(s2), oc2, oo2);
            if (ov3) mon(3, 64'(s3), oc3, oo3);
        end
    end

    task automatic drive(bit [3:0] m, logic [63:0] aa, logic [63:0] bb, bit sb, bit ci);
        @(negedge clk);
        en  = 1'b1;
        v   = m;
        a   = aa;
        b   = bb;
        sub = sb;
        cin = ci;
    endtask

    // Hand-computed 16-bit vector: s0 for the wrapping instance, s1 for the saturating one.
    task automatic dir(logic [15:0] aa, logic [15:0] bb, bit sb, bit ci,
                       logic [15:0] sw, logic [15:0] ss, bit c, bit o);
        exp_t e;
        drive(4'b0011, 64'(aa), 64'(bb), sb, ci);
        e.c = c;
        e.o = o;
        e.due = 0;
        e.s = 64'(sw);
        push(0, e);
        e.s = 64'(ss);
        push(1, e);
    endtask

    task automatic rnd();
        logic [63:0] aa, bb;
        bit          sb, ci;
        aa = {$urandom, $urandom};
        bb = {$urandom, $urandom};
        sb = 1'($urandom_range(0, 1));
        ci = 1'($urandom_range(0, 1));
        drive(4'hF, aa, bb, sb, ci);
        for (int i = 0; i < 4; i++) push(i, model(i, aa, bb, sb, ci));
    endtask

    task automatic stall();
        @(negedge clk);
        en = 1'b0;
        v  = 4'hF;
        a  = {$urandom, $urandom};
        b  = {$urandom, $urandom};
    endtask

    task automatic drain(string n);
        int k;
        k = 0;
        drive(4'b0, '0, '0, 1'b0, 1'b0);
        while (qsize() != 0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check({n, " pending"}, 64'(qsize()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ops;
        // Reset with the pipeline stalled: reset must still win.
        repeat (3) @(negedge clk);
        check("w16 rst ctl", 64'({ov0, oc0, oo0}), 64'd0);
        check("w16 rst s", 64'(s0), 64'd0);
        check("w16s rst ctl", 64'({ov1, oc1, oo1}), 64'd0);
        check("w16s rst s", 64'(s1), 64'd0);
        check("w24 rst ctl", 64'({ov2, oc2, oo2}), 64'd0);
        check("w24 rst s", 64'(s2), 64'd0);
        check("w5 rst ctl", 64'({ov3, oc3, oo3}), 64'd0);
        check("w5 rst s", 64'(s3), 64'd0);
        rst = 1'b0;

        //   a        b        sub  cin  s(wrap)  s(sat)   c  ovf
        dir(16'hFFFF, 16'h0001, 0, 0, 16'h0000, 16'h0000, 1, 0);
        dir(16'h0005, 16'h0007, 1, 0, 16'hFFFE, 16'hFFFE, 0, 0);
        dir(16'h0007, 16'h0005, 1, 0, 16'h0002, 16'h0002, 1, 0);
        dir(16'h7FFF, 16'h0001, 0, 0, 16'h8000, 16'h7FFF, 0, 1);
        dir(16'h8000, 16'h0001, 1, 0, 16'h7FFF, 16'h8000, 1, 1);
        dir(16'h1234, 16'h0001, 0, 1, 16'h1236, 16'h1236, 0, 0);
        dir(16'h0010, 16'h0010, 1, 1, 16'hFFFF, 16'hFFFF, 0, 0);
        dir(16'h8000, 16'h8000, 0, 0, 16'h0000, 16'h8000, 1, 1);
        dir(16'h0000, 16'h8000, 1, 0, 16'h8000, 16'h7FFF, 0, 1);
        dir(16'hFFFF, 16'hFFFF, 0, 1, 16'hFFFF, 16'hFFFF, 1, 0);
        drain("directed");

        // Back-to-back stream with a three-cycle stall; operands offered during it are ignored.
        for (int n = 0; n < 100; n++) begin
            if (n == 40) repeat (3) stall();
            rnd();
        end
        drain("stream");

        // Reset mid-flight, asserted together with a stall.
        repeat (4) rnd();
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b0;
        v   = 4'b0;
        q0.delete();
        q1.delete();
        q2.delete();
        q3.delete();
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;
        rnd();
        drain("after reset");

        // Random sweep with bubbles and stalls.
        ops = 0;
        while (ops < 1000) begin
            case ($urandom_range(0, 9))
                0:       stall();
                1:       drive(4'b0, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b1);
                default: begin
                    rnd();
                    ops++;
                end
            endcase
        end
        drain("sweep");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ksa_pipe_addsub.md
Name: ksa_pipe_addsub

Overview:
- Parametrised, pipelined Kogge-Stone adder/subtractor.
- Successor to the fixed 16-bit combinational KSA used in the FFT butterfly datapath.
- Registers every prefix level so wide butterflies close timing at the FFT clock.
- Adds a subtract mode, a borrow-in, signed overflow/saturation, and a valid/stall pipeline.

Parameters:
- WIDTH, 16, operand and sum width in bits; legal range 2..64, any value.
- SAT, 0, 1 = clamp signed result on overflow, 0 = wrap.
- LEVELS, ceil(log2(WIDTH)), number of prefix levels. Derived localparam; do not override.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_en  in  1  pipeline advance enable; 0 = hold all stages (stall).
- i_valid  in  1  operands valid this cycle.
- i_sub  in  1  0 = a+b+cin, 1 = a-b-cin (cin acts as borrow-in).
- i_cin  in  1  carry/borrow in.
- i_a  in  WIDTH  operand A (two's complement).
- i_b  in  WIDTH  operand B (two's complement).
- o_valid  out  1  result valid.
- o_s  out  WIDTH  sum/difference.
- o_carry  out  1  carry out of MSB; in subtract mode 1 = no borrow.
- o_ovf  out  1  signed overflow of the unsaturated result.

Behaviour:
- Operand preparation:
  - b' = i_sub ? ~i_b : i_b.
  - Effective cin = i_sub ? ~i_cin : i_cin.
  - p = a^b', g = a&b'.
  - Carry-in folded into bit 0: g0 = a0&b'0 | p0&cin.
- Stage 0 (prep register): registers p, g, the original p (kept for the sum XOR), cin, i_valid, and the MSB signs of a and b'.
- Stages 1..LEVELS: one registered Kogge-Stone level each.
  - Level k, span d = 2^(k-1), for i >= d: G_i = G_i | P_i & G_(i-d), P_i = P_i & P_(i-d).
  - For i < d: pass through unchanged.
  - The original p, cin, valid and sign bits travel alongside.
- Output stage (registered):
  - s_i = p_i ^ c_i, with c_0 = cin and c_i = G_(i-1).
  - o_carry = G_(WIDTH-1).
  - o_ovf = (a_msb == b'_msb) && (s_msb != a_msb).
- Saturation: if SAT=1 and o_ovf, o_s = a_msb ? 100..0 : 011..1. o_ovf still reports 1.
- Latency: LEVELS+2 enabled cycles from input to o_valid (WIDTH=16: 6 cycles; WIDTH=24: 7 cycles). Throughput is one operation per enabled cycle.
- Stall: with i_en=0, every register (data and valid) holds and outputs are frozen. i_valid/operands presented during a stall are ignored, not queued.
- Valid tracking: the valid bit shifts with the data. A bubble (i_valid=0) produces o_valid=0 after the same latency. Data registers of a bubble need not be cleared, but o_s/o_carry/o_ovf must be ignored when o_valid=0.
- Reset:
  - i_rst=1 clears all valid bits, o_s, o_carry and o_ovf to 0 on the next edge.
  - Reset takes priority over i_en=0.
  - Reset mid-flight discards all in-flight operations; the first o_valid after deassertion comes exactly LEVELS+2 enabled cycles after the first accepted i_valid.
- Width rule: no internal truncation. o_s is exactly WIDTH bits; the carry goes to o_carry only.
- Non-power-of-two WIDTH: levels whose span d >= WIDTH do not occur; the top level reaches the full width.

Test Plan:
- WIDTH=16, SAT=0, add: a=0xFFFF, b=0x0001, cin=0 -> after 6 cycles o_s=0x0000, o_carry=1, o_ovf=0, o_valid=1 for exactly 1 cycle.
- WIDTH=16, sub: a=0x0005, b=0x0007, cin=0 -> o_s=0xFFFE, o_carry=0 (borrow). Same with a=7, b=5 -> o_s=0x0002, o_carry=1.
- WIDTH=16, overflow: a=0x7FFF, b=0x0001, add, SAT=0 -> o_s=0x8000, o_ovf=1. With SAT=1 -> o_s=0x7FFF, o_ovf=1. Sub a=0x8000, b=0x0001, SAT=1 -> o_s=0x8000, o_ovf=1.
- Back-to-back stream of 100 random operand pairs with a 3-cycle i_en=0 gap inserted at cycle 40 -> outputs match a+b+cin / a-b-cin reference in order, with the gap adding exactly 3 cycles. No duplicated or lost results.
- Reset mid-flight: 4 valid ops issued, i_rst pulsed on cycle 3 -> no o_valid from those ops. Next op after reset appears exactly 6 cycles later.
- WIDTH=24 and WIDTH=5 random sweep (1000 ops each, random i_sub/i_cin) -> bit-exact vs model. Latency 7 and 5 cycles respectively.
